// File: rtl/pll_reconf_pkg.sv
// PLL reconfiguration controller: shared opcodes, status codes, FSM states.
// No ports; imported by pll_reconf_sync and pll_reconf_ctrl.
package pll_reconf_pkg;

  localparam logic [1:0] OPC_NOP  = 2'b00;
  localparam logic [1:0] OPC_WR   = 2'b01;
  localparam logic [1:0] OPC_RD   = 2'b10;
  localparam logic [1:0] OPC_ADDR = 2'b11;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_LOCK_TMO = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_RDWAIT,
    S_RST,
    S_LOCKWAIT,
    S_RSP
  } state_e;

endpackage

// File: rtl/pll_reconf_sync.sv
// Two-flop synchroniser, async active-low reset to 0.
// Ports: clk, rst_n, d_i (async input), q_o (synchronised output).
module pll_reconf_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/pll_reconf_ctrl.sv
// PLL dynamic-reconfiguration port controller: turns single register
// read/write/commit requests into MDOPC sequences and a reset/relock step.
// Ports: req_* request (valid/ready), rsp_* one-cycle response, md_* PLL
// reconfig port, pll_reset/pll_lock, lock_lost/lock_loss_cnt monitor.
// Optional macro PLL_RECONF_LOCK_MON_EN enables the IDLE lock-loss monitor.
module pll_reconf_ctrl
  import pll_reconf_pkg::*;
#(
  parameter int READ_LAT     = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_commit,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       busy,
  output logic [1:0] md_opc,
  output logic       md_ainc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int LW = $clog2(READ_LAT + 1);
  localparam int MW = (TW > RW) ? TW : RW;
  localparam int CW = (MW > LW) ? MW : LW;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       shadow_vld_q, shadow_vld_d;
  logic [7:0] shadow_addr_q, shadow_addr_d;

  logic       ready_q, ready_d;
  logic       rspv_q, rspv_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] status_q, status_d;
  logic       busy_q, busy_d;
  logic [1:0] opc_q, opc_d;
  logic       ainc_q, ainc_d;
  logic [7:0] wdi_q, wdi_d;
  logic       prst_q, prst_d;

  logic lock_s;
  logic accept;
  logic lock_ok;
  logic tmo;
  logic rd_done;
  logic rst_done;

  pll_reconf_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  assign accept   = req_valid && (state_q == S_IDLE);
  // First three LOCKWAIT cycles may still see pre-reset lock state.
  assign lock_ok  = (cnt_q >= CW'(3)) && lock_s;
  assign tmo      = cnt_q == CW'(LOCK_TIMEOUT - 1);
  assign rd_done  = cnt_q == CW'(READ_LAT - 1);
  assign rst_done = cnt_q == CW'(RST_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      shadow_vld_q  <= 1'b0;
      shadow_addr_q <= '0;
      ready_q       <= 1'b1;
      rspv_q        <= 1'b0;
      rdata_q       <= '0;
      status_q      <= ST_OK;
      busy_q        <= 1'b0;
      opc_q         <= OPC_NOP;
      ainc_q        <= 1'b0;
      wdi_q         <= '0;
      prst_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      shadow_vld_q  <= shadow_vld_d;
      shadow_addr_q <= shadow_addr_d;
      ready_q       <= ready_d;
      rspv_q        <= rspv_d;
      rdata_q       <= rdata_d;
      status_q      <= status_d;
      busy_q        <= busy_d;
      opc_q         <= opc_d;
      ainc_q        <= ainc_d;
      wdi_q         <= wdi_d;
      prst_q        <= prst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (req_commit)
            state_d = S_RST;
          else if (shadow_vld_q && (req_addr == shadow_addr_q))
            state_d = S_ACCESS;
          else
            state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_ACCESS;
      S_ACCESS: begin
        cnt_d   = '0;
        state_d = write_q ? S_RSP : S_RDWAIT;
      end
      S_RDWAIT: begin
        if (rd_done) state_d = S_RSP;
        else         cnt_d   = cnt_q + CW'(1);
      end
      S_RST: begin
        if (rst_done) begin
          state_d = S_LOCKWAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOCKWAIT: begin
        if (lock_ok || tmo) state_d = S_RSP;
        else                cnt_d   = cnt_q + CW'(1);
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each registered pin
  // lines up with the state it belongs to.
  always_comb begin
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    shadow_vld_d  = shadow_vld_q;
    shadow_addr_d = shadow_addr_q;
    rdata_d       = rdata_q;
    status_d      = status_q;
    opc_d         = OPC_NOP;
    wdi_d         = '0;
    if (accept) begin
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    unique case (state_q)
      S_IDLE:   if (accept) status_d = ST_OK;
      S_ADDR: begin
        shadow_addr_d = addr_q;
        shadow_vld_d  = 1'b1;
      end
      S_ACCESS: shadow_addr_d = shadow_addr_q + 8'd1;
      S_RDWAIT: if (rd_done) rdata_d = md_rdo;
      S_RST:    shadow_vld_d = 1'b0;
      S_LOCKWAIT: begin
        if (lock_ok)  status_d = ST_OK;
        else if (tmo) status_d = ST_LOCK_TMO;
      end
      default: ;
    endcase
    unique case (1'b1)
      (state_d == S_ADDR): begin
        opc_d = OPC_ADDR;
        wdi_d = addr_d;
      end
      (state_d == S_ACCESS): begin
        opc_d = write_d ? OPC_WR : OPC_RD;
        wdi_d = write_d ? wdata_d : 8'h00;
      end
      default: ;
    endcase
    ready_d = state_d == S_IDLE;
    busy_d  = state_d != S_IDLE;
    rspv_d  = state_d == S_RSP;
    ainc_d  = state_d == S_ACCESS;
    prst_d  = state_d == S_RST;
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rspv_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;
  assign busy       = busy_q;
  assign md_opc     = opc_q;
  assign md_ainc    = ainc_q;
  assign md_wdi     = wdi_q;
  assign pll_reset  = prst_q;

`ifdef PLL_RECONF_LOCK_MON_EN
  logic       lock_d1_q;
  logic       lost_q;
  logic [7:0] lcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_d1_q <= 1'b0;
      lost_q    <= 1'b0;
      lcnt_q    <= '0;
    end else begin
      lock_d1_q <= lock_s;
      if (accept && req_commit) begin
        lost_q <= 1'b0;
        lcnt_q <= '0;
      end else if ((state_q == S_IDLE) && lock_d1_q && !lock_s) begin
        lost_q <= 1'b1;
        if (lcnt_q != 8'hFF) lcnt_q <= lcnt_q + 8'd1;
      end
    end
  end

  assign lock_lost     = lost_q;
  assign lock_loss_cnt = lcnt_q;
`else
  assign lock_lost     = 1'b0;
  assign lock_loss_cnt = 8'h00;
`endif

endmodule

// File: doc/pll_reconf_ctrl.md
Name: pll_reconf_ctrl

Overview:
- Controller that drives the PLL dynamic-reconfiguration port (MDOPC/MDAINC/MDWDI, MDRDO) on the mdclk domain.
- Converts single register read/write requests from the system-control logic into port opcode sequences.
- Sequences the commit step: PLL reset pulse, then wait for lock with timeout, then report status.
- Sits directly upstream of the PLL wrapper; its outputs connect straight to the wrapper's mdopc/mdainc/mdwdi/reset pins.

Parameters:
- READ_LAT, 2, cycles from read opcode until md_rdo is valid.
- RST_CYCLES, 16, cycles pll_reset is held high during commit (>=1).
- LOCK_TIMEOUT, 65535, max cycles in LOCKWAIT before timeout (counter width = $clog2(LOCK_TIMEOUT+1)).

Ports:
- clk  in  1  mdclk-domain clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1=write, 0=read (ignored when req_commit=1)
- req_commit  in  1  1=reset/relock sequence instead of register access
- req_addr  in  8  register address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read data; held until next read completes
- rsp_status  out  2  00 OK, 01 lock timeout
- busy  out  1  state != IDLE
- md_opc  out  2  00 NOP, 01 write, 10 read, 11 load address
- md_ainc  out  1  address auto-increment strobe
- md_wdi  out  8  address or write data
- md_rdo  in  8  read data from PLL
- pll_reset  out  1  PLL reset
- pll_lock  in  1  PLL lock (async; synchronised internally)
- lock_lost  out  1  sticky lock-loss flag (optional feature)
- lock_loss_cnt  out  8  saturating lock-loss count (optional feature)

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_status=0, busy=0, md_opc=00, md_ainc=0, md_wdi=0, pll_reset=0, shadow_vld=0, lock_lost=0, lock_loss_cnt=0.
- All outputs are registered.
- pll_lock passes through a 2-flop synchroniser to produce lock_s.
- States: IDLE, ADDR, ACCESS, RDWAIT, RST, LOCKWAIT, RSP.
- IDLE: accept on req_valid & req_ready, latching all req_* fields. Transitions:
  - commit -> RST;
  - shadow_vld & req_addr==shadow_addr -> ACCESS;
  - otherwise -> ADDR.
- ADDR (1 cycle): md_opc=11, md_wdi=addr; shadow_addr<=addr, shadow_vld<=1; -> ACCESS.
- ACCESS (1 cycle): md_opc=01 with md_wdi=wdata, or md_opc=10. md_ainc=1; shadow_addr increments (8-bit wrap, 0xFF->0x00). Write -> RSP; read -> RDWAIT.
- RDWAIT: md_opc=00. Counts READ_LAT-1 cycles, so md_rdo is sampled exactly READ_LAT cycles after the ACCESS cycle; -> RSP.
- RST: pll_reset=1 for exactly RST_CYCLES cycles; shadow_vld<=0; -> LOCKWAIT.
- LOCKWAIT: pll_reset=0; counter starts at 0.
  - lock_s is ignored for the first 3 cycles to flush stale sync state.
  - lock_s=1 -> RSP with status 00.
  - Counter reaching LOCK_TIMEOUT -> RSP with status 01.
  - If both occur in the same cycle, lock wins.
- RSP (1 cycle): rsp_valid=1, status valid; -> IDLE. Read, write and commit responses carry status 00 unless the commit timed out.
- Latency from accept cycle to rsp_valid:
  - write: 3 cycles (2 when the address phase is skipped);
  - read: 3+READ_LAT (2+READ_LAT when skipped);
  - commit: RST_CYCLES + lock cycles + 1.
- md_opc returns to 00 in every state other than ADDR/ACCESS.
- rst_n asserted mid-operation aborts immediately: all outputs go to reset values and pll_reset drops to 0. No response is generated for the in-flight request.
- Requests presented while busy are held by the requester (valid/ready); the block neither drops nor queues them.

Optional Feature:
- Macro PLL_RECONF_LOCK_MON_EN.
- Defined:
  - A falling edge of lock_s while in IDLE sets lock_lost and increments lock_loss_cnt (saturates at 255).
  - Accepting a commit request clears both.
  - Edges during RST/LOCKWAIT are not counted.
- Undefined: lock_lost and lock_loss_cnt are tied 0 and no monitor logic is synthesised.

Decomposition:
- Package pll_reconf_pkg:
  - MDOPC constants (OPC_NOP, OPC_WR, OPC_RD, OPC_ADDR);
  - status codes (ST_OK, ST_LOCK_TMO);
  - state enum.
- One sub-module: pll_reconf_sync (2-flop synchroniser, async active-low reset to 0), instantiated for pll_lock.

Test Plan:
- Write addr 0x12 data 0xA5 from reset -> md_opc 11/0x12 at cycle 1, 01/0xA5 at cycle 2, md_ainc=1 at cycle 2, rsp_valid at cycle 3, status 00.
- Follow with a write to addr 0x13 -> no ADDR cycle: ACCESS at cycle 1, rsp at cycle 2. Then write to 0xFF followed by 0x00 -> wrap causes the second address phase to be skipped.
- Read addr 0x20 with model returning 0x5C READ_LAT=2 after opcode 10 -> rsp_rdata=0x5C, rsp_valid 5 cycles after accept.
- Commit with model lock rising 40 cycles after reset release -> pll_reset high exactly 16 cycles, rsp status 00, shadow invalidated (next access issues ADDR).
- Commit with lock held 0 and LOCK_TIMEOUT=100 -> rsp status 01 after 100 LOCKWAIT cycles. Commit with lock stuck at 1 -> still waits 3 cycles, then status 00.
- rst_n pulsed during RDWAIT -> no rsp_valid, req_ready=1, md_opc=00 after release. With PLL_RECONF_LOCK_MON_EN, 3 lock drops in IDLE -> lock_loss_cnt=3, lock_lost=1, both cleared on next commit accept.
